// File: rtl/xillybus_mem8_bridge_if.sv
// Host stream, seek and fabric-side register signals of the 32-word mem_8 bridge.
// master = host/fabric side, slave = the bridge itself.
interface xillybus_mem8_bridge_if;
   logic        user_r_mem_8_rden;
   logic [31:0] user_r_mem_8_data;
   logic        user_r_mem_8_empty;
   logic        user_r_mem_8_eof;
   logic        user_r_mem_8_open;

   logic        user_w_mem_8_wren;
   logic [31:0] user_w_mem_8_data;
   logic        user_w_mem_8_full;
   logic        user_w_mem_8_open;

   logic [4:0]  user_mem_8_addr;
   logic        user_mem_8_addr_update;

   logic [4:0]  loc_addr;
   logic        loc_we;
   logic [31:0] loc_wdata;
   logic        loc_ack;
   logic        loc_re;
   logic [31:0] loc_rdata;

   logic [15:0] wr_count;

   modport master (
      output user_r_mem_8_rden, user_r_mem_8_open,
      output user_w_mem_8_wren, user_w_mem_8_data, user_w_mem_8_open,
      output user_mem_8_addr, user_mem_8_addr_update,
      output loc_addr, loc_we, loc_wdata, loc_re,
      input  user_r_mem_8_data, user_r_mem_8_empty, user_r_mem_8_eof,
      input  user_w_mem_8_full, loc_ack, loc_rdata, wr_count
   );

   modport slave (
      input  user_r_mem_8_rden, user_r_mem_8_open,
      input  user_w_mem_8_wren, user_w_mem_8_data, user_w_mem_8_open,
      input  user_mem_8_addr, user_mem_8_addr_update,
      input  loc_addr, loc_we, loc_wdata, loc_re,
      output user_r_mem_8_data, user_r_mem_8_empty, user_r_mem_8_eof,
      output user_w_mem_8_full, loc_ack, loc_rdata, wr_count
   );
endinterface

// File: rtl/xillybus_mem8_bridge.sv
// 32x32 memory shared between a seekable host read/write stream pair and a
// fabric-side register port; host reads go through a 2-entry prefetch buffer.
module xillybus_mem8_bridge (
   input  logic                   bus_clk,
   input  logic                   bus_rst,
   xillybus_mem8_bridge_if.slave  bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DEPTH  = 32;
   localparam int unsigned CNT_W  = 16;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              exhausted_q, exhausted_d;
   logic [CNT_W-1:0]  wr_count_q, wr_count_d;
   logic              loc_ack_q, loc_ack_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [DATA_W-1:0] loc_rdata_q, loc_rdata_d;
   logic [DATA_W-1:0] buf0_q, buf0_d;
   logic [DATA_W-1:0] buf1_q, buf1_d;

   logic              host_wr;
   logic              loc_wr;
   logic [ADDR_W-1:0] wr_addr;
   logic              flush;
   logic              pop;
   logic              fetch;
   logic [DATA_W-1:0] fetch_word;

   // Next-state logic for pointers, prefetch buffer, counters and local port
   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      cnt_d       = cnt_q;
      exhausted_d = exhausted_q;
      wr_count_d  = wr_count_q;
      loc_ack_d   = 1'b0;
      rd_data_d   = rd_data_q;
      loc_rdata_d = loc_rdata_q;
      buf0_d      = buf0_q;
      buf1_d      = buf1_q;

      host_wr    = bus.user_w_mem_8_wren & bus.user_w_mem_8_open;
      wr_addr    = bus.user_mem_8_addr_update ? bus.user_mem_8_addr : wptr_q;
      // Masking with loc_ack keeps a request still held during its ack cycle from writing twice
      loc_wr     = bus.loc_we & ~host_wr & ~loc_ack_q;
      flush      = bus.user_mem_8_addr_update | ~bus.user_r_mem_8_open;
      pop        = bus.user_r_mem_8_rden & (cnt_q != 2'd0);
      fetch      = bus.user_r_mem_8_open & ~exhausted_q & ~flush &
                   ((cnt_q < 2'd2) | pop);
      fetch_word = mem[rptr_q];

      if (host_wr) begin
         wptr_d = ADDR_W'(wr_addr + 5'd1);
         if (wr_count_q != {CNT_W{1'b1}}) begin
            wr_count_d = CNT_W'(wr_count_q + 16'd1);
         end
      end else if (bus.user_mem_8_addr_update) begin
         wptr_d = bus.user_mem_8_addr;
      end

      loc_ack_d = loc_wr;
      if (bus.loc_re) begin
         loc_rdata_d = mem[bus.loc_addr];
      end

      if (pop) begin
         rd_data_d = buf0_q;
      end

      if (flush) begin
         cnt_d       = 2'd0;
         exhausted_d = 1'b0;
         rptr_d      = bus.user_mem_8_addr_update ? bus.user_mem_8_addr : '0;
      end else begin
         case ({pop, fetch})
            2'b10: begin
               buf0_d = buf1_q;
               cnt_d  = 2'(cnt_q - 2'd1);
            end
            2'b01: begin
               if (cnt_q == 2'd0) buf0_d = fetch_word;
               else               buf1_d = fetch_word;
               cnt_d = 2'(cnt_q + 2'd1);
            end
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  buf0_d = fetch_word;
               end else begin
                  buf0_d = buf1_q;
                  buf1_d = fetch_word;
               end
            end
            default: ;
         endcase
         if (fetch) begin
            rptr_d = ADDR_W'(rptr_q + 5'd1);
            // Reads never wrap: the last word ends the stream until the next seek/close
            if (rptr_q == {ADDR_W{1'b1}}) exhausted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         cnt_q       <= '0;
         exhausted_q <= 1'b0;
         wr_count_q  <= '0;
         loc_ack_q   <= 1'b0;
         rd_data_q   <= '0;
         loc_rdata_q <= '0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         cnt_q       <= cnt_d;
         exhausted_q <= exhausted_d;
         wr_count_q  <= wr_count_d;
         loc_ack_q   <= loc_ack_d;
         rd_data_q   <= rd_data_d;
         loc_rdata_q <= loc_rdata_d;
      end
   end

   // Prefetch storage carries no reset; occupancy alone says what is valid
   always_ff @(posedge bus_clk) begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
   end

   // Memory contents survive reset; reset only blocks writes in its own cycle
   always_ff @(posedge bus_clk) begin
      if (!bus_rst) begin
         if (host_wr) begin
            mem[wr_addr] <= bus.user_w_mem_8_data;
         end else if (loc_wr) begin
            mem[bus.loc_addr] <= bus.loc_wdata;
         end
      end
   end

   assign bus.user_r_mem_8_data  = rd_data_q;
   assign bus.user_r_mem_8_empty = (cnt_q == 2'd0);
   assign bus.user_r_mem_8_eof   = bus.user_r_mem_8_open & exhausted_q & (cnt_q == 2'd0);
   assign bus.user_w_mem_8_full  = 1'b0;
   assign bus.loc_ack            = loc_ack_q;
   assign bus.loc_rdata          = loc_rdata_q;
   assign bus.wr_count           = wr_count_q;

endmodule

// File: tb/tb_xillybus_mem8_bridge.sv
// Randomized scoreboard bench for xillybus_mem8_bridge: a word-array model of the
// memory supplies the expected read streams and local read data.
module tb_xillybus_mem8_bridge;
   logic bus_clk = 1'b0;
   logic bus_rst;
   always #5 bus_clk = ~bus_clk;

   xillybus_mem8_bridge_if bus ();
   xillybus_mem8_bridge dut (.bus_clk(bus_clk), .bus_rst(bus_rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_m [32];
   int          wp_m  = 0;
   int          cnt_m = 0;
   logic [31:0] exp_rd  [$];
   logic [31:0] exp_lrd [$];
   logic        pop_pend = 1'b0;
   logic        lrd_pend = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: compare whatever the DUT presents one edge after a pop / local read
   always @(negedge bus_clk) begin
      if (pop_pend) begin
         if (exp_rd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_extra actual=%h required=no_word", bus.user_r_mem_8_data);
         end else begin
            check("rd_data", bus.user_r_mem_8_data, exp_rd.pop_front());
         end
      end
      if (lrd_pend) begin
         if (exp_lrd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL loc_rd_extra actual=%h required=no_word", bus.loc_rdata);
         end else begin
            check("loc_rdata", bus.loc_rdata, exp_lrd.pop_front());
         end
      end
      pop_pend = !bus_rst && bus.user_r_mem_8_rden && !bus.user_r_mem_8_empty;
      lrd_pend = !bus_rst && bus.loc_re;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge bus_clk);
      #1;
   endtask

   task automatic model_write(input logic [31:0] d);
      mem_m[wp_m] = d;
      wp_m = (wp_m + 1) % 32;
      if (cnt_m < 65535) cnt_m++;
   endtask

   task automatic hwrite(input logic [31:0] d, input bit seek, input logic [4:0] a, input bit open);
      bus.user_w_mem_8_wren      = 1'b1;
      bus.user_w_mem_8_data      = d;
      bus.user_w_mem_8_open      = open;
      bus.user_mem_8_addr_update = seek;
      bus.user_mem_8_addr        = a;
      if (seek) wp_m = int'(a);
      if (open) model_write(d);
      tick();
      bus.user_w_mem_8_wren      = 1'b0;
      bus.user_mem_8_addr_update = 1'b0;
      bus.user_w_mem_8_open      = 1'b1;
   endtask

   task automatic lwrite(input logic [4:0] a, input logic [31:0] d, input bit also_read);
      bus.loc_we    = 1'b1;
      bus.loc_addr  = a;
      bus.loc_wdata = d;
      bus.loc_re    = also_read;
      if (also_read) exp_lrd.push_back(mem_m[a]);
      tick();
      bus.loc_re = 1'b0;
      @(negedge bus_clk);
      check("loc_ack", 32'(bus.loc_ack), 32'd1);
      mem_m[a] = d;
      tick();
      bus.loc_we = 1'b0;
      @(negedge bus_clk);
      check("loc_ack_single", 32'(bus.loc_ack), 32'd0);
   endtask

   task automatic lread(input logic [4:0] a);
      bus.loc_re   = 1'b1;
      bus.loc_addr = a;
      exp_lrd.push_back(mem_m[a]);
      tick();
      bus.loc_re = 1'b0;
   endtask

   // Seek both pointers; expected stream is a snapshot of words a..31
   task automatic rseek(input logic [4:0] a);
      bus.user_r_mem_8_rden = 1'b0;
      tick();
      tick();
      exp_rd.delete();
      for (int i = int'(a); i < 32; i++) exp_rd.push_back(mem_m[i]);
      wp_m = int'(a);
      bus.user_mem_8_addr_update = 1'b1;
      bus.user_mem_8_addr        = a;
      tick();
      bus.user_mem_8_addr_update = 1'b0;
      @(negedge bus_clk);
      check("seek_empty_n1", 32'(bus.user_r_mem_8_empty), 32'd1);
      check("seek_eof_n1", 32'(bus.user_r_mem_8_eof), 32'd0);
      tick();
      @(negedge bus_clk);
      check("seek_empty_n2", 32'(bus.user_r_mem_8_empty), 32'd0);
   endtask

   task automatic rrand(input int n);
      for (int i = 0; i < n; i++) begin
         bus.user_r_mem_8_rden = 1'($urandom_range(0, 1));
         tick();
      end
   endtask

   task automatic rdrain(input int nrand);
      int n;
      rrand(nrand);
      bus.user_r_mem_8_rden = 1'b1;
      n = 0;
      while (exp_rd.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (exp_rd.size() != 0) begin
         errors++;
         $display("FAIL rd_timeout actual=%0d_left required=0_left", exp_rd.size());
         exp_rd.delete();
      end
      bus.user_r_mem_8_rden = 1'b0;
      tick();
      @(negedge bus_clk);
      check("drain_eof", 32'(bus.user_r_mem_8_eof), 32'd1);
      check("drain_empty", 32'(bus.user_r_mem_8_empty), 32'd1);
   endtask

   task automatic write_phase(input int nops);
      for (int i = 0; i < nops; i++) begin
         case ($urandom_range(0, 5))
            0, 1: hwrite($urandom, ($urandom_range(0, 3) == 0), 5'($urandom), 1'b1);
            2:    hwrite($urandom, 1'($urandom_range(0, 1)), 5'($urandom), 1'b0);
            3:    lwrite(5'($urandom), $urandom, 1'($urandom_range(0, 1)));
            4:    lread(5'($urandom));
            default: tick();
         endcase
      end
      tick();
      @(negedge bus_clk);
      check("wr_count", 32'(bus.wr_count), 32'(cnt_m));
   endtask

   initial begin
      logic [31:0] snap_old;
      bus_rst                    = 1'b1;
      bus.user_r_mem_8_rden      = 1'b0;
      bus.user_r_mem_8_open      = 1'b0;
      bus.user_w_mem_8_wren      = 1'b0;
      bus.user_w_mem_8_data      = '0;
      bus.user_w_mem_8_open      = 1'b1;
      bus.user_mem_8_addr        = '0;
      bus.user_mem_8_addr_update = 1'b0;
      bus.loc_addr               = '0;
      bus.loc_we                 = 1'b0;
      bus.loc_wdata              = '0;
      bus.loc_re                 = 1'b0;
      tick();
      tick();
      @(negedge bus_clk);
      check("rst_empty", 32'(bus.user_r_mem_8_empty), 32'd1);
      check("rst_eof", 32'(bus.user_r_mem_8_eof), 32'd0);
      check("rst_data", bus.user_r_mem_8_data, 32'd0);
      check("rst_loc_rdata", bus.loc_rdata, 32'd0);
      check("rst_loc_ack", 32'(bus.loc_ack), 32'd0);
      check("rst_wr_count", 32'(bus.wr_count), 32'd0);
      check("full_const", 32'(bus.user_w_mem_8_full), 32'd0);
      tick();
      bus_rst = 1'b0;

      // Fill words 0..31 with 0x11..0x30 and stream them back
      for (int i = 0; i < 32; i++) hwrite(32'h11 + 32'(i), (i == 0), 5'd0, 1'b1);
      @(negedge bus_clk);
      check("fill_wr_count", 32'(bus.wr_count), 32'd32);
      bus.user_r_mem_8_open = 1'b1;
      rseek(5'd0);
      check("fill_first", exp_rd[0], 32'h11);
      rdrain(10);

      // Write pointer wraps from 31 to 0
      hwrite(32'hA000_001F, 1'b1, 5'd31, 1'b1);
      hwrite(32'hA000_0000, 1'b0, 5'd0, 1'b1);
      lread(5'd0);
      lread(5'd31);

      // Seek near the top of memory: two words then end of stream
      rseek(5'd30);
      rdrain(0);

      // Re-seek mid-read with a full prefetch buffer
      rseek(5'd0);
      rrand(6);
      rseek(5'd5);
      rdrain(4);

      // Buffered words are snapshots of memory at fetch time
      rseek(5'd10);
      tick();
      snap_old = mem_m[10];
      hwrite(32'h5A5A_0010, 1'b0, 5'd0, 1'b1);
      check("snap_head", exp_rd[0], snap_old);
      rdrain(0);
      lread(5'd10);

      // Host writes take priority over a held local write
      bus.loc_we    = 1'b1;
      bus.loc_addr  = 5'd3;
      bus.loc_wdata = 32'hCAFE_0003;
      for (int i = 0; i < 4; i++) begin
         hwrite($urandom, (i == 0), 5'd10, 1'b1);
         @(negedge bus_clk);
         check("prio_no_ack", 32'(bus.loc_ack), 32'd0);
      end
      tick();
      @(negedge bus_clk);
      check("prio_ack", 32'(bus.loc_ack), 32'd1);
      mem_m[3] = 32'hCAFE_0003;
      tick();
      bus.loc_we = 1'b0;
      @(negedge bus_clk);
      check("prio_ack_single", 32'(bus.loc_ack), 32'd0);
      check("prio_wr_count", 32'(bus.wr_count), 32'(cnt_m));
      lread(5'd3);

      // Randomized write phases, each followed by a random seek and read-out
      for (int ph = 0; ph < 8; ph++) begin
         write_phase(30);
         rseek(5'($urandom));
         rdrain($urandom_range(0, 20));
      end

      // Closing the read stream flushes it; reopening restarts at word 0
      bus.user_r_mem_8_open = 1'b0;
      tick();
      tick();
      @(negedge bus_clk);
      check("closed_empty", 32'(bus.user_r_mem_8_empty), 32'd1);
      check("closed_eof", 32'(bus.user_r_mem_8_eof), 32'd0);
      tick();
      exp_rd.delete();
      for (int i = 0; i < 32; i++) exp_rd.push_back(mem_m[i]);
      bus.user_r_mem_8_open = 1'b1;
      tick();
      rdrain(5);

      // Reset with a full buffer, pending local write and competing inputs
      rseek(5'd7);
      tick();
      bus_rst                    = 1'b1;
      bus.loc_we                 = 1'b1;
      bus.loc_addr               = 5'd4;
      bus.loc_wdata              = 32'hDEAD_0004;
      bus.user_w_mem_8_wren      = 1'b1;
      bus.user_w_mem_8_data      = 32'h0000_0055;
      bus.user_mem_8_addr_update = 1'b1;
      bus.user_mem_8_addr        = 5'd9;
      bus.user_r_mem_8_rden      = 1'b1;
      tick();
      bus.user_w_mem_8_wren      = 1'b0;
      bus.user_mem_8_addr_update = 1'b0;
      bus.user_r_mem_8_rden      = 1'b0;
      @(negedge bus_clk);
      check("rst2_empty", 32'(bus.user_r_mem_8_empty), 32'd1);
      check("rst2_eof", 32'(bus.user_r_mem_8_eof), 32'd0);
      check("rst2_loc_ack", 32'(bus.loc_ack), 32'd0);
      check("rst2_wr_count", 32'(bus.wr_count), 32'd0);
      check("rst2_data", bus.user_r_mem_8_data, 32'd0);
      tick();
      bus_rst    = 1'b0;
      bus.loc_we = 1'b0;
      @(negedge bus_clk);
      check("rst2_no_ack_a", 32'(bus.loc_ack), 32'd0);
      tick();
      @(negedge bus_clk);
      check("rst2_no_ack_b", 32'(bus.loc_ack), 32'd0);
      cnt_m = 0;
      wp_m  = 0;
      exp_rd.delete();
      hwrite(32'h0000_0077, 1'b0, 5'd0, 1'b1);
      lread(5'd0);
      lread(5'd4);
      rseek(5'd0);
      rdrain(3);

      // Saturating write counter
      for (int i = 0; i < 70000; i++) begin
         bus.user_w_mem_8_wren = 1'b1;
         bus.user_w_mem_8_data = 32'(i);
         model_write(32'(i));
         tick();
      end
      bus.user_w_mem_8_wren = 1'b0;
      tick();
      @(negedge bus_clk);
      check("sat_wr_count", 32'(bus.wr_count), 32'h0000_FFFF);
      rseek(5'd0);
      rdrain(0);

      tick();
      tick();
      check("loc_rd_queue_empty", 32'(exp_lrd.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
